// File: rtl/reg_dump_uart_tx.sv
// Purpose: snapshot R0..R7 + zero/carry flags and send them as one framed 8N1 UART byte stream.
// Latency: start bit drives out the cycle after the accepting edge; frame = bytes*10*CLKS_PER_BIT cycles.
// Backpressure: requests while busy merge into one pending frame sent back-to-back; DUMP_CHECKSUM_EN appends a sum byte.
module reg_dump_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        DUMP_REQ,
    input  logic [15:0] Reg0,
    input  logic [15:0] Reg1,
    input  logic [15:0] Reg2,
    input  logic [15:0] Reg3,
    input  logic [15:0] Reg4,
    input  logic [15:0] Reg5,
    input  logic [15:0] Reg6,
    input  logic [15:0] Reg7,
    input  logic        Zero_IN,
    input  logic        Carry_IN,
    output logic        TX,
    output logic        BUSY,
    output logic        DONE
);

`ifdef DUMP_CHECKSUM_EN
    localparam int NUM_BYTES = 19;
`else
    localparam int NUM_BYTES = 18;
`endif
    localparam logic [4:0]        LAST_BYTE = 5'(NUM_BYTES - 1);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [4:0]         byte_q, byte_d;
    logic               pend_q, pend_d;
    logic               done_q, done_d;
    logic               tx_q;
    logic               snap_en;
    logic [7:0][15:0]   snap_q;
    logic               zero_q, carry_q;
    logic [3:0]         reg_idx;
    logic [7:0]         byte_val;
    logic               baud_end;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]         csum_q;
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        snap_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (DUMP_REQ) begin
                    snap_en = 1'b1;
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        // Completion edge: a pending or live request restarts without visiting IDLE.
                        done_d = 1'b1;
                        byte_d = '0;
                        pend_d = 1'b0;
                        if (pend_q || DUMP_REQ) begin
                            snap_en = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        byte_d  = byte_q + 1'b1;
                        state_d = START;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && DUMP_REQ && !snap_en) pend_d = 1'b1;
    end

    // Byte 0 is the constant sync byte, so the mux never needs the snapshot being captured this edge.
    always_comb begin
        reg_idx  = 4'(byte_d - 5'd1);
        byte_val = SYNC_BYTE;
        if (byte_d == 5'd0)       byte_val = SYNC_BYTE;
        else if (byte_d <= 5'd16) byte_val = reg_idx[0] ? snap_q[reg_idx[3:1]][7:0]
                                                        : snap_q[reg_idx[3:1]][15:8];
        else if (byte_d == 5'd17) byte_val = {6'b0, zero_q, carry_q};
`ifdef DUMP_CHECKSUM_EN
        else                      byte_val = csum_q;
`else
        else                      byte_val = 8'h00;
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
            snap_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            tx_q    <= (state_d == START) ? 1'b0 :
                       (state_d == DATA)  ? byte_val[bit_d] : 1'b1;
            if (snap_en) begin
                snap_q  <= {Reg7, Reg6, Reg5, Reg4, Reg3, Reg2, Reg1, Reg0};
                zero_q  <= Zero_IN;
                carry_q <= Carry_IN;
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Sum each payload byte as it becomes current; complete by the time the final byte is loaded.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            csum_q <= '0;
        else if (snap_en)
            csum_q <= '0;
        else if (state_q == STOP && state_d == START && byte_d != LAST_BYTE)
            csum_q <= csum_q + byte_val;
    end
`endif

    assign TX   = tx_q;
    assign BUSY = (state_q != IDLE);
    assign DONE = done_q;

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Directed/random bench for reg_dump_uart_tx: UART decoder plus frame model built from register values.
module tb_reg_dump_uart_tx;

    localparam int CPB = 4;
`ifdef DUMP_CHECKSUM_EN
    localparam int NB = 19;
`else
    localparam int NB = 18;
`endif
    localparam int FRAME_CYC = NB * 10 * CPB;

    logic        CLK;
    logic        RST_N;
    logic        DUMP_REQ;
    logic [15:0] regs [8];
    logic        zf, cf;
    logic        TX, BUSY, DONE;

    int n_assert = 0;
    int n_fail   = 0;
    int ticks    = 0;
    int dones    = 0;
    int frame_err = 0;
    int t0, d0;

    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];

    reg_dump_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .DUMP_REQ (DUMP_REQ),
        .Reg0     (regs[0]),
        .Reg1     (regs[1]),
        .Reg2     (regs[2]),
        .Reg3     (regs[3]),
        .Reg4     (regs[4]),
        .Reg5     (regs[5]),
        .Reg6     (regs[6]),
        .Reg7     (regs[7]),
        .Zero_IN  (zf),
        .Carry_IN (cf),
        .TX       (TX),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // UART receiver: samples mid-bit, pushes each byte after its stop-bit sample.
    int         mon_t  = 0;
    bit         mon_on = 1'b0;
    logic [7:0] mon_byte;
    always @(negedge CLK) begin
        if (RST_N !== 1'b1) begin
            mon_on = 1'b0;
        end else if (!mon_on) begin
            if (TX === 1'b0) begin
                mon_on = 1'b1;
                mon_t  = 0;
            end
        end else begin
            mon_t++;
        end
        if (mon_on && (mon_t % CPB) == CPB / 2) begin
            if (mon_t / CPB == 0) begin
                if (TX !== 1'b0) frame_err++;
            end else if (mon_t / CPB <= 8) begin
                mon_byte[mon_t / CPB - 1] = TX;
            end else begin
                if (TX !== 1'b1) frame_err++;
                rx_q.push_back(mon_byte);
                mon_on = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        ticks++;
        if (DONE === 1'b1) dones++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic rand_regs();
        foreach (regs[i]) regs[i] = 16'($urandom);
        zf = 1'($urandom);
        cf = 1'($urandom);
    endtask

    // Reference frame: sync, each register MSB byte first, flags, optional sum of payload bytes.
    task automatic push_frame();
        int sum = 0;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(regs[i] / 256);
            exp_q.push_back(regs[i] % 256);
            sum += regs[i] / 256 + regs[i] % 256;
        end
        exp_q.push_back(8'(2 * zf + cf));
        sum += 2 * zf + cf;
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(8'(sum % 256));
`endif
    endtask

    task automatic request();
        DUMP_REQ = 1'b1;
        push_frame();
        tick();
        DUMP_REQ = 1'b0;
        t0 = ticks;
        d0 = dones;
    endtask

    task automatic cmp_frames(input string tag);
        int n;
        check({tag, " byte_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s byte[%0d]", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic finish_frames(input string tag, input int nframes);
        int k = 0;
        while (BUSY !== 1'b0 && k < 20000) begin
            tick();
            k++;
        end
        check({tag, " no_timeout"}, 32'(k < 20000), 32'd1);
        check({tag, " busy_cycles"}, 32'(ticks - t0), 32'(nframes * FRAME_CYC));
        check({tag, " done_at_end"}, 32'(DONE), 32'd1);
        check({tag, " done_count"}, 32'(dones - d0), 32'(nframes));
        tick();
        check({tag, " done_width"}, 32'(DONE), 32'd0);
        check({tag, " tx_idle"}, 32'(TX), 32'd1);
        cmp_frames(tag);
    endtask

    initial begin
        RST_N    = 1'b0;
        DUMP_REQ = 1'b1;
        rand_regs();
        run(3);
        check("reset tx", 32'(TX), 32'd1);
        check("reset busy", 32'(BUSY), 32'd0);
        check("reset done", 32'(DONE), 32'd0);

        // Release with request held: frame starts on the first edge.
        push_frame();
        RST_N = 1'b1;
        tick();
        check("release busy", 32'(BUSY), 32'd1);
        check("release tx", 32'(TX), 32'd0);
        DUMP_REQ = 1'b0;
        t0 = ticks;
        d0 = dones;
        finish_frames("release", 1);

        // Basic frame.
        run(3);
        foreach (regs[i]) regs[i] = 16'h0000;
        regs[0] = 16'h1234;
        zf = 1'b1;
        cf = 1'b0;
        check("basic idle busy", 32'(BUSY), 32'd0);
        request();
        check("basic first tx", 32'(TX), 32'd0);
        finish_frames("basic", 1);

        // All-0101 pattern, both flags set.
        foreach (regs[i]) regs[i] = 16'h0101;
        zf = 1'b1;
        cf = 1'b1;
        request();
        finish_frames("pattern", 1);

        // Snapshot isolation.
        rand_regs();
        regs[3] = 16'hBEEF;
        request();
        run(100);
        rand_regs();
        regs[3] = 16'h0000;
        finish_frames("isolate", 1);

        // Three pulses during frame 1 merge into one back-to-back frame.
        rand_regs();
        request();
        run(100);
        DUMP_REQ = 1'b1; tick(); DUMP_REQ = 1'b0;
        run(200);
        DUMP_REQ = 1'b1; tick(); DUMP_REQ = 1'b0;
        run(100);
        rand_regs();
        run(100);
        DUMP_REQ = 1'b1; tick(); DUMP_REQ = 1'b0;
        push_frame();
        finish_frames("pending", 2);

        // Request held high: fresh snapshot per frame, the last request carried over as pending.
        rand_regs();
        DUMP_REQ = 1'b1;
        push_frame();
        tick();
        t0 = ticks;
        d0 = dones;
        run(100);
        rand_regs();
        push_frame();
        run(700);
        DUMP_REQ = 1'b0;
        rand_regs();
        push_frame();
        finish_frames("held", 3);

        // Reset at byte 7 data bit 3 (a zero bit).
        rand_regs();
        regs[3] = 16'h0000;
        request();
        run(297);
        check("abort pre_tx", 32'(TX), 32'd0);
        check("abort pre_busy", 32'(BUSY), 32'd1);
        RST_N = 1'b0;
        #1;
        check("abort tx", 32'(TX), 32'd1);
        check("abort busy", 32'(BUSY), 32'd0);
        check("abort done", 32'(DONE), 32'd0);
        d0 = dones;
        run(5);
        check("abort no_done", 32'(dones - d0), 32'd0);
        rx_q.delete();
        exp_q.delete();
        RST_N = 1'b1;
        run(2);
        rand_regs();
        request();
        finish_frames("post_abort", 1);

        check("framing errors", 32'(frame_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_dump_uart_tx.md
Name: reg_dump_uart_tx

Overview:
- Debug readout transmitter for the 16-bit pipelined RISC core.
- Consumes the core's exported architectural state: Reg0..Reg7 plus the current zero and carry flags.
- On request, snapshots that state and serialises it off-chip as a fixed framed byte stream over a UART 8N1 line.
- Sits beside the core top level. It observes only and never drives the core.

Parameters:
- CLKS_PER_BIT, 16, CLK cycles per UART bit (must be >= 2).
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- CLK  input  1  single system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- DUMP_REQ  input  1  level/pulse request to dump state; sampled each CLK.
- Reg0..Reg7  input  16 each  architectural registers R0..R7 from the core.
- Zero_IN  input  1  core current zero flag.
- Carry_IN  input  1  core current carry flag.
- TX  output  1  UART serial line, idle high.
- BUSY  output  1  high while a frame is pending or in transmission.
- DONE  output  1  one-cycle pulse when the last stop bit of a frame completes.

Behaviour:
- Reset, asynchronous on RST_N low: TX=1, BUSY=0, DONE=0, FSM=IDLE. All counters, the snapshot and the pending flag are cleared.
- Reset asserted mid-frame aborts the frame immediately. TX returns high asynchronously and no DONE pulse is produced.
- Clock and reset: one clock, CLK. Reset is asynchronous, active-low, named RST_N. All state is registered on rising CLK.
- Acceptance:
  - In IDLE with DUMP_REQ=1 at a rising edge, capture Reg0..Reg7, Zero_IN and Carry_IN into a snapshot register.
  - Set BUSY=1 and enter START.
- Frame content, byte order:
  - SYNC_BYTE.
  - R0[15:8], R0[7:0], R1[15:8], ... R7[7:0] (MSB byte first).
  - Flags byte {6'b0, Zero, Carry}.
  - Base frame = 18 bytes.
- Byte encoding:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Bytes are back-to-back with no idle gap between a stop bit and the next start bit.
- FSM states and transitions:
  - IDLE -> START on acceptance.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if bytes remain; otherwise IDLE.
- Byte index counter runs 0..17 (0..18 with the optional feature). The bit counter runs 0..7. The baud counter runs 0..CLKS_PER_BIT-1, reloads at each bit boundary and wraps cleanly.
- Latency: TX falls to 0 on the first edge after the acceptance edge. Total frame time = bytes*10*CLKS_PER_BIT cycles.
- Completion: on the cycle the final stop bit ends, DONE=1 for exactly one cycle and BUSY=0 on that same cycle.
- DUMP_REQ while BUSY:
  - Sets a single pending flag. Further requests while pending are merged.
  - When the frame completes and pending=1, skip IDLE: capture a new snapshot on the completion edge, clear pending, and start the next frame's start bit on the following cycle. BUSY stays 1, while DONE still pulses.
- DUMP_REQ held high continuously produces contiguous frames, each with a fresh snapshot.
- Register inputs are sampled only at the snapshot edge. Changes during transmission do not affect the frame in flight.

Optional Feature:
- Macro DUMP_CHECKSUM_EN.
- Defined: a 19th byte is appended after the flags byte. It is the 8-bit modulo-256 sum of bytes 1..17 (the sync byte is excluded), accumulated from the snapshot as bytes are loaded. Frame time = 190*CLKS_PER_BIT cycles.
- Undefined: no checksum logic, 18-byte frame, 180*CLKS_PER_BIT cycles.

Test Plan:
- Reset check: hold RST_N=0 with DUMP_REQ=1 -> TX=1, BUSY=0, DONE=0. Release RST_N -> frame starts on the next edge with DUMP_REQ still high.
- Basic frame, CLKS_PER_BIT=4:
  - Stimulus: R0=16'h1234, R1..R7=16'h0000, Zero=1, Carry=0, one-cycle DUMP_REQ.
  - Response: decoded bytes A5,12,34,00x14,02. DONE pulses exactly 720 cycles after the TX falling edge; BUSY is high for exactly 720 cycles.
- Snapshot isolation: change R3 from 16'hBEEF to 16'h0000 mid-frame -> the frame carries BE,EF for R3.
- Pending merge: issue three DUMP_REQ pulses during frame 1 ->
  - exactly two frames are sent, with no idle gap between them;
  - BUSY stays high between them;
  - two DONE pulses.
- Reset mid-frame: assert RST_N=0 at byte 7, bit 3 -> TX=1 immediately, no DONE. A following request yields a clean full frame.
- DUMP_CHECKSUM_EN, stimulus: R0..R7 = 16'h0101 each, Zero=1, Carry=1.
  - Byte 19 = (16*1 + 3) mod 256 = 8'h13.
  - Frame length = 760 cycles at CLKS_PER_BIT=4.
